// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a small byte FIFO,
// an FSM drains it onto tx, and loads from STATUS report FIFO/FSM state.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          overflow;

    logic hit;
    logic wr_txdata;
    logic wr_status;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bit_end;
    logic [7:0] head;
    logic unused_bits;

    assign hit       = (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata = mem_write & hit & ~addr[2];
    assign wr_status = mem_write & hit & addr[2];
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = wr_txdata & ~full;
    assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE);
    assign unused_bits = ^{write_data[31:8], addr[1:0]};

    // The FSM takes a new byte whenever it is idle, or right at the end of a
    // stop bit so consecutive frames run with no idle gap.
    assign pop = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Full is judged before the edge, so a pop on the same edge
            // does not rescue a store into a full FIFO.
            if (wr_status) begin
                overflow <= 1'b0;
            end else if (wr_txdata & full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!empty) begin
                        shift_reg <= head;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!empty) begin
                            shift_reg <= head;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        if (mem_read & hit & addr[2]) begin
            read_data = {28'b0, overflow, empty, full, busy};
        end
    end

endmodule
